seq_ser: RTL
============

Name: seq_ser

Overview:
Parallel-to-serial front end that feeds the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Buffers one word in a holding register.
- Shifts words out one bit per clock on ser_out; ser_out connects directly to the detector's seq_in.
- Between words, ser_out drives a fixed idle level so the detector always sees a defined bit.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_BIT, 0, level driven on ser_out whenever no word is being shifted.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din holds a valid word.
din_ready  output  1  holding register is empty; a word is accepted on any rising edge where din_valid and din_ready are both 1.
ser_out  output  1  serial bit stream, registered.
ser_sof  output  1  high for exactly the cycle in which the first bit of a word is on ser_out.
busy  output  1  a word is currently being shifted out.
underrun  output  1  one-cycle pulse when a word finishes and no next word is held.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - ser_out=IDLE_BIT, ser_sof=0, busy=0, underrun=0.
  - Holding register empty, so din_ready=1.
  - FSM to IDLE; bit counter cleared.
  - Reset mid-word discards both the word in flight and the held word.
- Storage:
  - hold_reg (WIDTH) plus hold_full flag.
  - shift_reg (WIDTH).
  - bit counter of $clog2(WIDTH) bits.
- din_ready = !hold_full, driven directly from a register with no combinational path from din_valid.
- Accept: on an edge with din_valid && din_ready, din is written to hold_reg and hold_full is set.
- FSM states: IDLE and SHIFT.
- IDLE:
  - ser_out=IDLE_BIT, busy=0.
  - On an edge where hold_full=1: load shift_reg from hold_reg and clear hold_full.
  - On that same edge: drive ser_out with the first bit, set ser_sof=1 and busy=1, set count to 0, and go to SHIFT.
  - Latency: a word accepted at edge E shows its first bit on ser_out after edge E+1.
  - A word cannot be accepted and transferred on the same edge, because din_ready=0 whenever hold_full=1.
- SHIFT:
  - Each edge advances count and presents the next bit; ser_sof=0 after the first bit.
  - Bit k of a word is on ser_out during cycle E+1+k, for k = 0..WIDTH-1.
- End of word: the edge where count==WIDTH-1 is the word's last bit.
  - If hold_full=1: reload from hold_reg exactly as in IDLE and stay in SHIFT. There is zero gap, and ser_sof=1 again.
  - If hold_full=0: go to IDLE with ser_out=IDLE_BIT, busy=0, and underrun=1 for one cycle.
- The hold register may be refilled at any time during SHIFT once it is empty. Because WIDTH is 2 or more, a continuous input stream produces a gapless output stream.
- Bit order:
  - MSB_FIRST=1 sends din[WIDTH-1] first, down to din[0].
  - MSB_FIRST=0 sends din[0] first, up to din[WIDTH-1].
- din_valid while din_ready=0:
  - The word is not taken and the upstream source must hold it.
  - The block never drops or duplicates a word.
- Illegal FSM encoding: return to IDLE with ser_out=IDLE_BIT.

Test Plan:
1. Single word, reset release, WIDTH=8, MSB_FIRST=1, din=8'hB6 presented for one accepting edge E:
   - ser_out is 1,0,1,1,0,1,1,0 during cycles E+1 to E+8, with ser_sof=1 only in cycle E+1 and busy=1 throughout.
   - Then ser_out=0, busy=0, and underrun=1 for one cycle at E+9.
2. Back-to-back, 8'hA5 followed by 8'h3C with din_valid held high:
   - 16 consecutive bits 10100101 00111100 with no idle cycle.
   - ser_sof pulses at bit 0 and bit 8.
   - underrun pulses only after the 16th bit.
3. Backpressure:
   - With one word shifting and a second word held, din_ready=0 and a third word on din stays unaccepted.
   - din_ready returns to 1 the cycle after the held word loads, and the third word then follows with no gap.
4. LSB-first, MSB_FIRST=0, din=8'h01: ser_out is 1,0,0,0,0,0,0,0, then IDLE_BIT.
5. Reset mid-word: assert rst_n=0 after the 3rd bit of 8'hFF.
   - Outputs immediately take their reset values, and the held word is lost.
   - After release, ser_out stays IDLE_BIT until a new word is accepted.
6. End-to-end with the detector: stream 8'h6D,8'hB6 into the detector's seq_in and compare its seq_out against a bit-level reference model, with no mismatch over 1000 random words.

Source files
------------

// File: rtl/seq_ser.sv
// Parallel-to-serial front end for the serial sequence detector.
// One-word holding register feeds a shift register; words chain with no idle gap.
module seq_ser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_sof,
  output logic             busy,
  output logic             underrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count;

  // Bit that leaves first for a given word alignment.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Moves the next bit to be sent into the first_bit position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready = ~hold_full;

  // Accepting into hold_reg and transferring out of it never share an edge,
  // since acceptance needs hold_full=0 and a transfer needs hold_full=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      count     <= '0;
      ser_out   <= IDLE_BIT;
      ser_sof   <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      ser_sof  <= 1'b0;
      underrun <= 1'b0;

      if (din_valid && !hold_full) begin
        hold_reg  <= din;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          ser_out <= IDLE_BIT;
          busy    <= 1'b0;
          count   <= '0;
          if (hold_full) begin
            shift_reg <= hold_reg;
            hold_full <= 1'b0;
            ser_out   <= first_bit(hold_reg);
            ser_sof   <= 1'b1;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (count == LAST) begin
            if (hold_full) begin
              shift_reg <= hold_reg;
              hold_full <= 1'b0;
              ser_out   <= first_bit(hold_reg);
              ser_sof   <= 1'b1;
              busy      <= 1'b1;
              count     <= '0;
            end else begin
              state    <= IDLE;
              ser_out  <= IDLE_BIT;
              busy     <= 1'b0;
              underrun <= 1'b1;
              count    <= '0;
            end
          end else begin
            count     <= count + 1'b1;
            shift_reg <= advance(shift_reg);
            ser_out   <= first_bit(advance(shift_reg));
          end
        end

        default: begin
          state   <= IDLE;
          ser_out <= IDLE_BIT;
          busy    <= 1'b0;
          count   <= '0;
        end
      endcase
    end
  end

endmodule
